weight_bank_buffer: RTL and testbench
=====================================

// Module: weight_bank_buffer
// PURPOSE
//  Parametrised, multi-bank weight buffer for the EPU. Replaces the single 180 KB weight SRAM wrapper.
//  Arbitrates one SRAM address space between two masters:
//   - host port: burst loads/readback, driven from the EPU AXI slave wrapper;
//   - EPU port: single-word accesses from the convolution datapath.
//  Adds bank interleaving, a host burst address counter, EPU stall signalling and out-of-range detection.
// PARAMETERS
//  DATA_W     32    word width (bits) of both ports and of every bank
//  BANK_NUM   4     number of SRAM banks (power of 2, >=1)
//  BANK_DEPTH 11520 words per bank; total words = BANK_NUM*BANK_DEPTH
//  LEN_W      8     burst length field width (beats-1, AXI style)
//  ADDR_W     $clog2(BANK_NUM*BANK_DEPTH)  word address width (derived, localparam)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       synchronous reset, active low
//  enb_i          in   1       slave select from EPU wrapper; host requests ignored when 0
//  host_req_i     in   1       host burst request (level, held until host_gnt_o)
//  host_we_i      in   1       1=write burst, 0=read burst (sampled with grant)
//  host_addr_i    in   32      byte start address (word index = host_addr_i[ADDR_W+1:2])
//  host_len_i     in   LEN_W   beats-1 (sampled with grant)
//  host_gnt_o     out  1       1-cycle grant pulse
//  host_wvalid_i  in   1       write beat valid
//  host_wdata_i   in   DATA_W  write beat data
//  host_wready_o  out  1       write beat accepted when wvalid&wready
//  host_rvalid_o  out  1       read beat valid
//  host_rdata_o   out  DATA_W  read beat data
//  host_rlast_o   out  1       last read beat
//  host_done_o    out  1       1-cycle pulse after last beat retired
//  host_err_o     out  1       sticky out-of-range flag; cleared by next grant
//  epu_cs_i       in   1       EPU access request
//  epu_we_i       in   1       EPU write enable
//  epu_addr_i     in   ADDR_W  EPU word address
//  epu_wdata_i    in   DATA_W  EPU write data
//  epu_rdata_o    out  DATA_W  EPU read data
//  epu_rvalid_o   out  1       EPU read data valid
//  epu_stall_o    out  1       1 = EPU request not accepted this cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - state=IDLE; counters=0;
//    - all outputs 0, except epu_stall_o, which is combinational from state.
//    - Reset mid-burst aborts the burst; no done pulse; SRAM contents are not cleared.
//  - Bank mapping: bank = word_addr % BANK_NUM (low bits); row = word_addr / BANK_NUM.
//  - SRAM read latency is 1 cycle:
//    - epu_rvalid_o / host_rvalid_o assert the cycle after the read was issued;
//    - the read data is routed from the bank latched at issue time.
//  - FSM states:
//    - IDLE   : EPU accesses served directly (epu_stall_o=0).
//               If enb_i & host_req_i: grant, latch we/len/addr, go HOST_R or HOST_W.
//    - HOST_W : each wvalid&wready beat writes at the counter address, then increments it.
//               After beat len+1 -> HOST_DONE. wready=1 throughout.
//    - HOST_R : one read is issued per cycle, len+1 reads in total.
//               Data returns with rvalid the next cycle; rlast marks the final beat.
//               Goes to HOST_DONE in the cycle the final beat is presented.
//    - HOST_DONE : host_done_o=1 for one cycle -> IDLE.
//  - EPU interaction:
//    - epu_stall_o=1 in HOST_R, HOST_W and HOST_DONE, and in the grant cycle itself.
//    - A stalled EPU request has no SRAM effect; the EPU must hold its request.
//  - Simultaneous events:
//    - host request and EPU request in the same IDLE cycle: host wins and the EPU is stalled.
//    - An EPU read issued the cycle before a grant still returns its rvalid in the grant cycle.
//  - Out-of-range (word_addr >= BANK_NUM*BANK_DEPTH, either port):
//    - writes are suppressed;
//    - reads return 0 with a normal rvalid;
//    - a host-side access sets host_err_o.
//  - Wrap-around: the host counter does not wrap; beats beyond the top are out of range.
//  - If enb_i drops mid-burst, the burst continues; enb_i gates grants only.
// CONFIGURATION
//  WEIGHT_BUF_PARITY_EN defined:
//   - each bank stores DATA_W+1 bits, the extra bit being even parity written on every write;
//   - on each read, parity is checked and a mismatch pulses par_err_o (extra output, 1 bit)
//     together with rvalid;
//   - data is passed through unchanged.
//  WEIGHT_BUF_PARITY_EN undefined: banks are DATA_W wide; no par_err_o port; no check logic.
// TESTING
//  1. Reset held 2 cycles mid HOST_W burst -> all outputs 0, state IDLE, no host_done_o.
//  2. Host write addr=0x0, len=7, data 0x100+i -> 8 beats accepted, done pulse.
//     Then EPU reads word 5 -> rvalid next cycle, rdata=0x105.
//  3. Host read addr=0x10, len=3 after step 2 -> rdata 0x104..0x107 on consecutive cycles.
//     rlast on the 4th beat; done pulse the cycle after.
//  4. Same-cycle host_req and EPU write to word 2 -> grant, epu_stall_o=1.
//     The EPU write lands only after HOST_DONE; readback shows the EPU value.
//  5. Host write addr=(BANK_NUM*BANK_DEPTH-2)*4, len=3 -> 2 beats written, 2 dropped.
//     host_err_o=1; reading back the dropped addresses returns 0.
//  6. With WEIGHT_BUF_PARITY_EN: force-flip one stored bit of word 3, then EPU read word 3
//     -> par_err_o=1 with rvalid. Without the macro the same bench compiles with no par_err_o port.

Source files
------------

// File: rtl/weight_bank_buffer.sv
// Banked weight SRAM shared by a host burst port and a single-word EPU port (optional parity: WEIGHT_BUF_PARITY_EN).
// Latency: grant combinational in IDLE; reads return rvalid one cycle after issue; done pulses one cycle after HOST_DONE.
// Backpressure: EPU stalled while a host burst owns the SRAM (grant cycle included); host write beats always accepted.
module weight_bank_buffer #(
    parameter  int DATA_W     = 32,
    parameter  int BANK_NUM   = 4,
    parameter  int BANK_DEPTH = 11520,
    parameter  int LEN_W      = 8,
    localparam int ADDR_W     = $clog2(BANK_NUM * BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enb_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [31:0]       host_addr_i,
    input  logic [LEN_W-1:0]  host_len_i,
    output logic              host_gnt_o,
    input  logic              host_wvalid_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_wready_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rlast_o,
    output logic              host_done_o,
    output logic              host_err_o,
    input  logic              epu_cs_i,
    input  logic              epu_we_i,
    input  logic [ADDR_W-1:0] epu_addr_i,
    input  logic [DATA_W-1:0] epu_wdata_i,
    output logic [DATA_W-1:0] epu_rdata_o,
    output logic              epu_rvalid_o,
    output logic              epu_stall_o
`ifdef WEIGHT_BUF_PARITY_EN
    ,
    output logic              par_err_o
`endif
);

    localparam int TOTAL   = BANK_NUM * BANK_DEPTH;
    // One spare bit above the larger of address/length so the burst counter never wraps back in range.
    localparam int CNT_W   = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam int BANK_W  = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int BANK_SH = $clog2(BANK_NUM);
    localparam int ROW_W   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
`ifdef WEIGHT_BUF_PARITY_EN
    localparam int MEM_W   = DATA_W + 1;
`else
    localparam int MEM_W   = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, HOST_W, HOST_R, HOST_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;
    logic               host_rvalid_q, host_rvalid_d;
    logic               host_rlast_q, host_rlast_d;
    logic               done_q, done_d;
    logic               epu_rvalid_q, epu_rvalid_d;
    logic [BANK_W-1:0]  rd_bank_q, rd_bank_d;
    logic               rd_oor_q, rd_oor_d;

    logic               host_gnt;
    logic               acc_en, acc_we, acc_host, acc_oor;
    logic [CNT_W-1:0]   acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [BANK_W-1:0]  acc_bank;
    logic [ROW_W-1:0]   acc_row;
    logic [MEM_W-1:0]   mem_wdata;
    logic [MEM_W-1:0]   rd_entry;
    logic [DATA_W-1:0]  rd_word;

    logic [MEM_W-1:0]   mem_q     [BANK_NUM][BANK_DEPTH];
    logic [MEM_W-1:0]   bank_rd_q [BANK_NUM];

    // Byte-offset and upper address bits carry no word-index information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{host_addr_i[31:ADDR_W+2], host_addr_i[1:0]};

    assign host_gnt = (state_q == IDLE) && enb_i && host_req_i;

    // Single SRAM access per cycle: EPU when IDLE and not losing to a grant, else the host counter.
    always_comb begin
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_host  = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        case (state_q)
            IDLE: begin
                if (!host_gnt && epu_cs_i) begin
                    acc_en    = 1'b1;
                    acc_we    = epu_we_i;
                    acc_addr  = CNT_W'(epu_addr_i);
                    acc_wdata = epu_wdata_i;
                end
            end
            HOST_W: begin
                if (host_wvalid_i) begin
                    acc_en    = 1'b1;
                    acc_we    = 1'b1;
                    acc_host  = 1'b1;
                    acc_addr  = cnt_q;
                    acc_wdata = host_wdata_i;
                end
            end
            HOST_R: begin
                acc_en   = 1'b1;
                acc_host = 1'b1;
                acc_addr = cnt_q;
            end
            default: ;
        endcase
    end

    // Low address bits pick the bank, the rest pick the row.
    assign acc_oor  = (acc_addr >= CNT_W'(TOTAL));
    assign acc_bank = BANK_W'(acc_addr % CNT_W'(BANK_NUM));
    assign acc_row  = ROW_W'(acc_addr >> BANK_SH);

`ifdef WEIGHT_BUF_PARITY_EN
    assign mem_wdata = {^acc_wdata, acc_wdata};
`else
    assign mem_wdata = acc_wdata;
`endif

    // SRAM banks: no reset on contents; accesses are blocked while reset is asserted so a burst aborts cleanly.
    always_ff @(posedge clk) begin
        if (rst_n && acc_en && !acc_oor) begin
            if (acc_we) begin
                mem_q[acc_bank][acc_row] <= mem_wdata;
            end else begin
                bank_rd_q[acc_bank] <= mem_q[acc_bank][acc_row];
            end
        end
    end

    // Burst FSM, counters and registered response flags.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_d        = beat_q;
        len_d         = len_q;
        err_d         = err_q;
        host_rvalid_d = 1'b0;
        host_rlast_d  = 1'b0;
        done_d        = 1'b0;
        epu_rvalid_d  = acc_en && !acc_we && !acc_host;
        rd_bank_d     = acc_bank;
        rd_oor_d      = acc_oor;
        if (acc_en && acc_host && acc_oor) begin
            err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (host_gnt) begin
                    state_d = host_we_i ? HOST_W : HOST_R;
                    cnt_d   = CNT_W'(host_addr_i[ADDR_W+1:2]);
                    beat_d  = '0;
                    len_d   = host_len_i;
                    err_d   = 1'b0;
                end
            end
            HOST_W: begin
                if (host_wvalid_i) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == len_q) begin
                        state_d = HOST_DONE;
                    end
                end
            end
            HOST_R: begin
                host_rvalid_d = 1'b1;
                host_rlast_d  = (beat_q == len_q);
                cnt_d         = cnt_q + CNT_W'(1);
                beat_d        = beat_q + LEN_W'(1);
                if (beat_q == len_q) begin
                    state_d = HOST_DONE;
                end
            end
            HOST_DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            len_q         <= '0;
            err_q         <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rlast_q  <= 1'b0;
            done_q        <= 1'b0;
            epu_rvalid_q  <= 1'b0;
            rd_bank_q     <= '0;
            rd_oor_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            err_q         <= err_d;
            host_rvalid_q <= host_rvalid_d;
            host_rlast_q  <= host_rlast_d;
            done_q        <= done_d;
            epu_rvalid_q  <= epu_rvalid_d;
            rd_bank_q     <= rd_bank_d;
            rd_oor_q      <= rd_oor_d;
        end
    end

    // Read data comes from the bank captured at issue; out-of-range reads return zero.
    assign rd_entry = bank_rd_q[rd_bank_q];
    assign rd_word  = rd_oor_q ? '0 : rd_entry[DATA_W-1:0];

    assign host_gnt_o    = host_gnt;
    assign host_wready_o = (state_q == HOST_W);
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rvalid_q ? rd_word : '0;
    assign host_rlast_o  = host_rlast_q;
    assign host_done_o   = done_q;
    assign host_err_o    = err_q;
    assign epu_rvalid_o  = epu_rvalid_q;
    assign epu_rdata_o   = epu_rvalid_q ? rd_word : '0;
    assign epu_stall_o   = (state_q != IDLE) || host_gnt;

`ifdef WEIGHT_BUF_PARITY_EN
    // Even parity over data+parity bit must reduce to 0 on a clean word.
    assign par_err_o = (host_rvalid_q || epu_rvalid_q) && !rd_oor_q && (^rd_entry);
`endif

endmodule

// File: tb/tb_weight_bank_buffer.sv
// Directed bench for weight_bank_buffer: EPU vector table plus host burst sequences.
// Latency: checks sampled 1-2 time units after the rising edge.
// Backpressure: EPU stall checked around host grants and bursts.
module tb_weight_bank_buffer;

    localparam int ADDR_W = 16;
    localparam int TOP    = 4 * 11520;

    logic        clk, rst_n, enb;
    logic        host_req, host_we, host_wvalid;
    logic [31:0] host_addr, host_wdata;
    logic [7:0]  host_len;
    logic        host_gnt, host_wready, host_rvalid, host_rlast, host_done, host_err;
    logic [31:0] host_rdata;
    logic        epu_cs, epu_we;
    logic [ADDR_W-1:0] epu_addr;
    logic [31:0] epu_wdata, epu_rdata;
    logic        epu_rvalid, epu_stall;
`ifdef WEIGHT_BUF_PARITY_EN
    logic        par_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd_exp [8];

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } epu_vec_t;

    epu_vec_t vecs [10];

    weight_bank_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enb_i        (enb),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_len_i   (host_len),
        .host_gnt_o   (host_gnt),
        .host_wvalid_i(host_wvalid),
        .host_wdata_i (host_wdata),
        .host_wready_o(host_wready),
        .host_rvalid_o(host_rvalid),
        .host_rdata_o (host_rdata),
        .host_rlast_o (host_rlast),
        .host_done_o  (host_done),
        .host_err_o   (host_err),
        .epu_cs_i     (epu_cs),
        .epu_we_i     (epu_we),
        .epu_addr_i   (epu_addr),
        .epu_wdata_i  (epu_wdata),
        .epu_rdata_o  (epu_rdata),
        .epu_rvalid_o (epu_rvalid),
        .epu_stall_o  (epu_stall)
`ifdef WEIGHT_BUF_PARITY_EN
        ,
        .par_err_o    (par_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
        host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_len = len;
        #1;
        chk("wr_gnt", 32'(host_gnt), 32'd1);
        chk("wr_gnt_stall", 32'(epu_stall), 32'd1);
        step();
        host_req = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            host_wvalid = 1'b1;
            host_wdata  = base + 32'(b);
            #1;
            chk("wr_wready", 32'(host_wready), 32'd1);
            step();
        end
        host_wvalid = 1'b0;
        #1;
        chk("wr_done_early", 32'(host_done), 32'd0);
        chk("wr_done_state_stall", 32'(epu_stall), 32'd1);
        step();
        chk("wr_done", 32'(host_done), 32'd1);
        chk("wr_after_stall", 32'(epu_stall), 32'd0);
    endtask

    task automatic host_read(input logic [31:0] addr, input logic [7:0] len);
        host_req = 1'b1; host_we = 1'b0; host_addr = addr; host_len = len;
        #1;
        chk("rd_gnt", 32'(host_gnt), 32'd1);
        step();
        host_req = 1'b0;
        chk("rd_err_clr", 32'(host_err), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            step();
            chk("rd_rvalid", 32'(host_rvalid), 32'd1);
            chk("rd_rdata", host_rdata, rd_exp[i]);
            chk("rd_rlast", 32'(host_rlast), (i == int'(len)) ? 32'd1 : 32'd0);
        end
        step();
        chk("rd_done", 32'(host_done), 32'd1);
        chk("rd_rvalid_end", 32'(host_rvalid), 32'd0);
    endtask

    task automatic epu_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        epu_cs = 1'b1; epu_we = 1'b0; epu_addr = addr;
        #1;
        chk("epu_rd_stall", 32'(epu_stall), 32'd0);
        step();
        epu_cs = 1'b0;
        chk("epu_rd_rvalid", 32'(epu_rvalid), 32'd1);
        chk("epu_rd_rdata", epu_rdata, exp);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'd100,   32'hA5A5_0001, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 16'd101,   32'h5A5A_0002, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 16'd100,   32'h0,         1'b1, 32'hA5A5_0001};
        vecs[3] = '{1'b1, 1'b0, 16'd101,   32'h0,         1'b1, 32'h5A5A_0002};
        vecs[4] = '{1'b1, 1'b1, 16'd46079, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 16'd46079, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b1, 16'd46080, 32'h1234_5678, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 16'd46080, 32'h0,         1'b1, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 16'd65535, 32'h0,         1'b1, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 16'd0,     32'h0,         1'b0, 32'h0};

        rst_n = 1'b0; enb = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_len = '0;
        host_wvalid = 1'b0; host_wdata = '0;
        epu_cs = 1'b0; epu_we = 1'b0; epu_addr = '0; epu_wdata = '0;
        step();
        step();

        // Reset state
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_wready", 32'(host_wready), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        chk("rst_rlast", 32'(host_rlast), 32'd0);
        chk("rst_done", 32'(host_done), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_epu_rvalid", 32'(epu_rvalid), 32'd0);
        chk("rst_epu_rdata", epu_rdata, 32'd0);
        chk("rst_stall", 32'(epu_stall), 32'd0);
        rst_n = 1'b1;
        step();

        // EPU single-word vector table, including top-of-range and out-of-range words
        for (int i = 0; i < 10; i++) begin
            epu_cs = vecs[i].cs; epu_we = vecs[i].we;
            epu_addr = vecs[i].addr; epu_wdata = vecs[i].wdata;
            #1;
            chk("vec_stall", 32'(epu_stall), 32'd0);
            step();
            chk("vec_rvalid", 32'(epu_rvalid), 32'(vecs[i].exp_rvalid));
            chk("vec_rdata", epu_rdata, vecs[i].exp_rdata);
        end
        epu_cs = 1'b0;

        // enb low gates the grant
        enb = 1'b0; host_req = 1'b1; host_we = 1'b1;
        #1;
        chk("enb_gnt", 32'(host_gnt), 32'd0);
        chk("enb_stall", 32'(epu_stall), 32'd0);
        step();
        chk("enb_wready", 32'(host_wready), 32'd0);
        host_req = 1'b0; enb = 1'b1;

        // Reset held 2 cycles in the middle of a write burst
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0; host_len = 8'd7;
        step();
        host_req = 1'b0;
        for (int b = 0; b < 3; b++) begin
            host_wvalid = 1'b1; host_wdata = 32'hBAD0 + 32'(b);
            step();
        end
        chk("mid_wready", 32'(host_wready), 32'd1);
        rst_n = 1'b0;
        step();
        step();
        chk("midrst_wready", 32'(host_wready), 32'd0);
        chk("midrst_gnt", 32'(host_gnt), 32'd0);
        chk("midrst_stall", 32'(epu_stall), 32'd0);
        chk("midrst_done", 32'(host_done), 32'd0);
        chk("midrst_rvalid", 32'(host_rvalid), 32'd0);
        rst_n = 1'b1; host_wvalid = 1'b0;
        step();
        chk("postrst_done0", 32'(host_done), 32'd0);
        step();
        chk("postrst_done1", 32'(host_done), 32'd0);

        // Host write burst then EPU readback of word 5
        host_write(32'h0, 8'd7, 32'h100);
        epu_read(16'd5, 32'h105);

        // Host read burst of words 4..7
        for (int i = 0; i < 4; i++) rd_exp[i] = 32'h104 + 32'(i);
        host_read(32'h10, 8'd3);

        // Same-cycle host request and EPU write: host wins, EPU write lands after the burst
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h8; host_len = 8'd0;
        epu_cs = 1'b1; epu_we = 1'b1; epu_addr = 16'd2; epu_wdata = 32'hCAFE_0002;
        #1;
        chk("race_gnt", 32'(host_gnt), 32'd1);
        chk("race_stall_gnt", 32'(epu_stall), 32'd1);
        step();
        host_req = 1'b0;
        #1;
        chk("race_stall_r", 32'(epu_stall), 32'd1);
        step();
        chk("race_rvalid", 32'(host_rvalid), 32'd1);
        chk("race_rdata_old", host_rdata, 32'h102);
        chk("race_rlast", 32'(host_rlast), 32'd1);
        chk("race_stall_done", 32'(epu_stall), 32'd1);
        step();
        chk("race_done", 32'(host_done), 32'd1);
        chk("race_stall_idle", 32'(epu_stall), 32'd0);
        step();
        epu_we = 1'b0;
        step();
        epu_cs = 1'b0;
        chk("race_epu_rvalid", 32'(epu_rvalid), 32'd1);
        chk("race_epu_rdata", epu_rdata, 32'hCAFE_0002);

        // Host write straddling the top of the address space
        host_write(32'((TOP - 2) * 4), 8'd3, 32'h500);
        chk("oor_wr_err", 32'(host_err), 32'd1);
        epu_read(16'(TOP - 2), 32'h500);
        epu_read(16'(TOP - 1), 32'h501);
        epu_read(16'(TOP),     32'h0);
        epu_read(16'(TOP + 1), 32'h0);
        rd_exp[0] = 32'h501; rd_exp[1] = 32'h0;
        host_read(32'((TOP - 1) * 4), 8'd1);
        chk("oor_rd_err", 32'(host_err), 32'd1);

`ifdef WEIGHT_BUF_PARITY_EN
        // Corrupt the stored parity bit of word 3 (bank 3, row 0)
        dut.mem_q[3][0][32] = ~dut.mem_q[3][0][32];
        epu_cs = 1'b1; epu_we = 1'b0; epu_addr = 16'd3;
        step();
        epu_cs = 1'b0;
        chk("par_rvalid", 32'(epu_rvalid), 32'd1);
        chk("par_err", 32'(par_err), 32'd1);
        chk("par_rdata", epu_rdata, 32'h103);
        epu_cs = 1'b1; epu_addr = 16'd4;
        step();
        epu_cs = 1'b0;
        chk("par_clean", 32'(par_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
